// File: rtl/pio_pkg.sv
// Shared constants for the debounced PIO peripheral: register word
// addresses, edge-capture modes and the debounce counter sizing helper.
package pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] PIO_ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUT_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int pio_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stability counter.
// The accepted value only follows the synchronized pin after it has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pin,
  output logic stable
);

  localparam int                 CNT_W    = pio_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Synchronize the pin, then count disagreement cycles; any match restarts.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= pin;
      sync      <= sync_meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO for switches and LEDs: debounced inputs, edge capture
// with maskable level interrupt, and atomic set/clear of output bits.
module pio_debounce_irq
  import pio_pkg::*;
#(
  parameter int                   IN_WIDTH        = 10,
  parameter int                   OUT_WIDTH       = 10,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter int                   EDGE_MODE       = 0,
  parameter logic [OUT_WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_irq,
  input  logic [IN_WIDTH-1:0]  chaves_export,
  output logic [OUT_WIDTH-1:0] leds_export
);

  logic [IN_WIDTH-1:0]  data_in;
  logic [IN_WIDTH-1:0]  stable_q;
  logic [IN_WIDTH-1:0]  edge_hit;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [IN_WIDTH-1:0]  cap_clr;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [OUT_WIDTH-1:0] data_out;
  logic [IN_WIDTH-1:0]  wr_in;
  logic [OUT_WIDTH-1:0] wr_out;
  logic [31:0]          rd_mux;
  logic                 unused_wd;

  assign wr_in     = avs_writedata[IN_WIDTH-1:0];
  assign wr_out    = avs_writedata[OUT_WIDTH-1:0];
  assign unused_wd = ^avs_writedata;

  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_db
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
        .clk_sys (clk_clk),
        .reset   (reset_reset),
        .pin     (chaves_export[gi]),
        .stable  (data_in[gi])
      );
    end
  endgenerate

  // Qualifying transitions of the debounced inputs, chosen by EDGE_MODE.
  always_comb begin
    edge_hit = data_in & ~stable_q;
    if (EDGE_MODE == EDGE_FALL) begin
      edge_hit = stable_q & ~data_in;
    end else if (EDGE_MODE == EDGE_ANY) begin
      edge_hit = stable_q ^ data_in;
    end
  end

  // Software write-1-clear mask for the capture register.
  always_comb begin
    cap_clr = '0;
    if (avs_write && (avs_address == PIO_ADDR_EDGE_CAP)) begin
      cap_clr = wr_in;
    end
  end

  // Edge history and capture; a new edge outranks a same-cycle clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable_q <= '0;
      edge_cap <= '0;
    end else begin
      stable_q <= data_in;
      edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
    end
  end

  // Writable control registers: output value, set/clear strobes, irq mask.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      data_out <= RESET_OUT;
      irq_mask <= '0;
    end else if (avs_write) begin
      case (avs_address)
        PIO_ADDR_DATA_OUT: data_out <= wr_out;
        PIO_ADDR_OUT_SET:  data_out <= data_out | wr_out;
        PIO_ADDR_OUT_CLR:  data_out <= data_out & ~wr_out;
        PIO_ADDR_IRQ_MASK: irq_mask <= wr_in;
        default:           ;
      endcase
    end
  end

  assign leds_export = data_out;
  assign avs_irq     = |(edge_cap & irq_mask);

  // Read mux over current register contents; unused and reserved read 0.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      PIO_ADDR_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = data_in;
      PIO_ADDR_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out;
      PIO_ADDR_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask;
      PIO_ADDR_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
      default:           ;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_debounce_irq.sv
module tb_pio_debounce_irq;

  localparam int IW = 10;
  localparam int OW = 10;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    addr = 3'd0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          irq;
  logic [IW-1:0] pins = '0;
  logic [OW-1:0] leds;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pio_debounce_irq #(
    .IN_WIDTH        (IW),
    .OUT_WIDTH       (OW),
    .DEBOUNCE_CYCLES (DB),
    .EDGE_MODE       (0),
    .RESET_OUT       (10'h155)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .avs_address   (addr),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_readdata  (rdata),
    .avs_irq       (irq),
    .chaves_export (pins),
    .leds_export   (leds)
  );

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  // Long enough for synchronizer plus debounce plus edge capture.
  task automatic settle();
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (leds !== 10'h155) begin errors++; $display("FAIL reset_leds: got %h expected %h", leds, 10'h155); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    avs_rd(3'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_data_in: got %h expected 0", d); end
    avs_rd(3'd1, d);
    checks++;
    if (d !== 32'h155) begin errors++; $display("FAIL reset_data_out: got %h expected 155", d); end
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_edge_cap: got %h expected 0", d); end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    logic [31:0] exp;
    @(negedge clk);
    addr = 3'd0; rd = 1'b1;
    for (int t = 0; t < 10; t++) begin
      pins[3] = ~pins[3];
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL bounce_data_in: got %h expected 0", rdata); end
      end
    end
    pins[3] = 1'b1;
    // Stable flips at the 10th edge; the held read shows it one edge later.
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp = (k == 11) ? 32'h8 : 32'h0;
      checks++;
      if (rdata !== exp) begin errors++; $display("FAIL debounce_latency k=%0d: got %h expected %h", k, rdata, exp); end
    end
    rd = 1'b0;
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL debounce_edge_cap: got %h expected 8", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL debounce_irq_unmasked: got %b expected 0", irq); end
  endtask

  task automatic test_irq_flow();
    logic [31:0] d;
    avs_wr(3'd3, 32'h8);
    avs_wr(3'd2, 32'h8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear: got %b expected 0", irq); end
    pins[3] = 1'b0;
    settle();
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL fall_not_captured: got %h expected 0", d); end
    pins[3] = 1'b1;
    settle();
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL irq_edge_cap: got %h expected 8", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_asserted: got %b expected 1", irq); end
    avs_wr(3'd3, 32'h8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL edge_cap_cleared: got %h expected 0", d); end
  endtask

  task automatic test_masking();
    logic [31:0] d;
    pins[5] = 1'b1;
    settle();
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL mask_edge_cap: got %h expected 20", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_blocked: got %b expected 0", irq); end
    avs_wr(3'd2, 32'h20);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq_enabled: got %b expected 1", irq); end
    avs_rd(3'd2, d);
    checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL mask_readback: got %h expected 20", d); end
    avs_wr(3'd3, 32'h20);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    avs_wr(3'd1, 32'hFFFF_F0F0);
    checks++;
    if (leds !== 10'h0F0) begin errors++; $display("FAIL data_out_write: got %h expected 0f0", leds); end
    avs_wr(3'd4, 32'h00F);
    checks++;
    if (leds !== 10'h0FF) begin errors++; $display("FAIL out_set: got %h expected 0ff", leds); end
    avs_wr(3'd5, 32'h030);
    checks++;
    if (leds !== 10'h0CF) begin errors++; $display("FAIL out_clr: got %h expected 0cf", leds); end
    avs_rd(3'd1, d);
    checks++;
    if (d !== 32'h0CF) begin errors++; $display("FAIL data_out_read: got %h expected 0cf", d); end
    avs_rd(3'd4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL out_set_read: got %h expected 0", d); end
    avs_rd(3'd6, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
    avs_wr(3'd0, 32'h3FF);
    avs_wr(3'd7, 32'h3FF);
    avs_rd(3'd0, d);
    checks++;
    if (d !== 32'h028) begin errors++; $display("FAIL data_in_ro: got %h expected 028", d); end
    checks++;
    if (leds !== 10'h0CF) begin errors++; $display("FAIL reserved_write: got %h expected 0cf", leds); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    avs_wr(3'd2, 32'h8);
    pins[3] = 1'b0;
    settle();
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL collision_pre: got %h expected 0", d); end
    pins[3] = 1'b1;
    // Capture lands on the 11th edge; aim the write-1-clear at that edge.
    repeat (10) @(negedge clk);
    addr = 3'd3; wdata = 32'h8; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b expected 1", irq); end
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL collision_set_wins: got %h expected 8", d); end
    avs_wr(3'd3, 32'h8);
    avs_rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL collision_later_clear: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_irq_flow();
    test_masking();
    test_set_clear();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
